// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - fetch-to-decode pipeline register with 2-entry skid buffer and flush
//
// Purpose:
//   Captures {instr, pc, pc_inc4} from fetch and presents it to decode over a
//   valid/ready handshake. A main entry drives the decode side and a skid entry
//   absorbs the one extra beat that arrives while if_ready is still high. This
//   lets if_ready come straight from a flop, so decode backpressure never
//   reaches fetch combinationally.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   if_valid, if_ready  fetch-side handshake (if_ready is registered)
//   if_instr, if_pc, if_pc_inc4   fetch payload (N bits each)
//   id_valid, id_ready  decode-side handshake
//   id_instr, id_pc, id_pc_inc4   decode payload (id_instr = NOP when invalid)
//   flush               drop every buffered entry and any coincident fetch beat
//   stall_cnt           32-bit decode stall counter (IF_ID_STALL_CNT_EN only)
//
// Optional feature macro: IF_ID_STALL_CNT_EN
module if_id_pipe #(
  parameter int           N   = 32,
  parameter logic [N-1:0] NOP = N'(32'h00000013)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_valid,
  input  logic [N-1:0] if_instr,
  input  logic [N-1:0] if_pc,
  input  logic [N-1:0] if_pc_inc4,
  output logic         if_ready,
  output logic         id_valid,
  output logic [N-1:0] id_instr,
  output logic [N-1:0] id_pc,
  output logic [N-1:0] id_pc_inc4,
  input  logic         id_ready,
  input  logic         flush
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0]  stall_cnt
`endif
);

  // Occupancy: EMPTY = nothing, ONE = main only, TWO = main + skid.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         if_ready_q, if_ready_d;
  logic [N-1:0] main_instr_q, main_instr_d;
  logic [N-1:0] main_pc_q, main_pc_d;
  logic [N-1:0] main_inc4_q, main_inc4_d;
  logic [N-1:0] skid_instr_q, skid_instr_d;
  logic [N-1:0] skid_pc_q, skid_pc_d;
  logic [N-1:0] skid_inc4_q, skid_inc4_d;

  logic in_xfer;
  logic out_xfer;

  assign id_valid = (state_q != S_EMPTY);
  assign in_xfer  = if_valid && if_ready_q;
  assign out_xfer = id_valid && id_ready;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    main_inc4_d  = main_inc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_inc4_d  = skid_inc4_q;

    if (flush) begin
      // Entries are invalidated through occupancy only; main data is kept so
      // id_pc / id_pc_inc4 keep showing their last values.
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d      = S_ONE;
            main_instr_d = if_instr;
            main_pc_d    = if_pc;
            main_inc4_d  = if_pc_inc4;
          end
        end
        S_ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d      = S_TWO;
            skid_instr_d = if_instr;
            skid_pc_d    = if_pc;
            skid_inc4_d  = if_pc_inc4;
          end else if (in_xfer && out_xfer) begin
            main_instr_d = if_instr;
            main_pc_d    = if_pc;
            main_inc4_d  = if_pc_inc4;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // if_ready is low here, so only the skid-to-main move can happen.
          if (out_xfer) begin
            state_d      = S_ONE;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
            main_inc4_d  = skid_inc4_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end

    // Registering the look-ahead keeps if_ready == (state_q != S_TWO)
    // while still coming directly from a flop.
    if_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      if_ready_q   <= 1'b1;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      main_inc4_q  <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_inc4_q  <= '0;
    end else begin
      state_q      <= state_d;
      if_ready_q   <= if_ready_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      main_inc4_q  <= main_inc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_inc4_q  <= skid_inc4_d;
    end
  end

  assign if_ready   = if_ready_q;
  assign id_instr   = id_valid ? main_instr_q : NOP;
  assign id_pc      = main_pc_q;
  assign id_pc_inc4 = main_inc4_q;

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles where decode holds off a valid entry; a flush cycle is not
  // a stall. Wraps naturally at 32 bits.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_ready && !flush) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// tb/tb_if_id_pipe.sv - scoreboard bench for if_id_pipe
//
// Purpose: directed stimulus with a queue-based scoreboard; a negedge monitor
// pops and compares every decode-side transfer and checks hold stability.
// Optional feature macro: IF_ID_STALL_CNT_EN
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] inc4;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_inc4;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_inc4;
  logic        id_ready;
  logic        flush;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  ent_t sb[$];
  ent_t mon_exp;
  logic prev_hold = 1'b0;
  ent_t prev_ent;

  if_id_pipe #(.N(32), .NOP(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_inc4 (if_pc_inc4),
    .if_ready   (if_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_inc4 (id_pc_inc4),
    .id_ready   (id_ready),
    .flush      (flush)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: inputs change #1 after posedge, so at negedge everything that
  // governs the coming edge is stable. Pop before push keeps FIFO order.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_assert++;
        if ({id_instr, id_pc, id_pc_inc4} !== prev_ent) begin
          n_fail++;
          $display("FAIL hold_stable: got %h/%h/%h, required %h/%h/%h",
                   id_instr, id_pc, id_pc_inc4, prev_ent.instr, prev_ent.pc, prev_ent.inc4);
        end
      end
      if (!id_valid) begin
        n_assert++;
        if (id_instr !== NOP) begin
          n_fail++;
          $display("FAIL nop_when_invalid: got %h, required %h", id_instr, NOP);
        end
      end
      if (id_valid && id_ready) begin
        n_assert++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got instr %h pc %h, required no transfer", id_instr, id_pc);
        end else begin
          mon_exp = sb.pop_front();
          n_pops++;
          if ({id_instr, id_pc, id_pc_inc4} !== mon_exp) begin
            n_fail++;
            $display("FAIL out_data: got %h/%h/%h, required %h/%h/%h",
                     id_instr, id_pc, id_pc_inc4, mon_exp.instr, mon_exp.pc, mon_exp.inc4);
          end
        end
      end
      prev_hold = id_valid && !id_ready && !flush;
      prev_ent  = {id_instr, id_pc, id_pc_inc4};
      if (flush) begin
        sb.delete();
      end else if (if_valid && if_ready) begin
        sb.push_back('{if_instr, if_pc, if_pc + 32'd4});
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    if_valid   = v;
    if_instr   = instr;
    if_pc      = pc;
    if_pc_inc4 = pc + 32'd4;
    id_ready   = rdy;
    flush      = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  logic [31:0] a_tab [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
  logic [31:0] b_tab [3] = '{32'hB0000001, 32'hB0000002, 32'hB0000003};

  initial begin
    rst = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 32'h00000100, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc_inc4", id_pc_inc4, 32'd0);

    // Streaming with id_ready held high
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, a_tab[i], 32'(i * 4), 1'b1, 1'b0);
      step();
      chk("stream_valid", {31'd0, id_valid}, 32'd1);
      chk("stream_instr", id_instr, a_tab[i]);
      chk("stream_pc", id_pc, 32'(i * 4));
      chk("stream_pc_inc4", id_pc_inc4, 32'(i * 4 + 4));
      chk("stream_if_ready", {31'd0, if_ready}, 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("stream_drained", {31'd0, id_valid}, 32'd0);

    // Backpressure: B0 main, B1 skid, B2 refused until decode drains
    drive(1'b1, b_tab[0], 32'h40, 1'b0, 1'b0);
    step();
    chk("bp_c1_if_ready", {31'd0, if_ready}, 32'd1);
    chk("bp_c1_instr", id_instr, b_tab[0]);
    drive(1'b1, b_tab[1], 32'h44, 1'b0, 1'b0);
    step();
    chk("bp_c2_if_ready", {31'd0, if_ready}, 32'd0);
    chk("bp_c2_instr", id_instr, b_tab[0]);
    drive(1'b1, b_tab[2], 32'h48, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_full_if_ready", {31'd0, if_ready}, 32'd0);
      chk("bp_full_instr", id_instr, b_tab[0]);
    end
    drive(1'b1, b_tab[2], 32'h48, 1'b1, 1'b0);
    step();
    chk("bp_drain1_instr", id_instr, b_tab[1]);
    chk("bp_drain1_if_ready", {31'd0, if_ready}, 32'd1);
    step();
    chk("bp_drain2_instr", id_instr, b_tab[2]);
    chk("bp_drain2_pc", id_pc, 32'h48);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("bp_drained", {31'd0, id_valid}, 32'd0);

    // Flush with full buffer and a C9 offered by fetch
    drive(1'b1, 32'hC0000007, 32'h80, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hC0000008, 32'h84, 1'b0, 1'b0);
    step();
    chk("fl_full_if_ready", {31'd0, if_ready}, 32'd0);
    drive(1'b1, 32'hC0000009, 32'h88, 1'b0, 1'b1);
    step();
    chk("fl_id_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_if_ready", {31'd0, if_ready}, 32'd1);
    chk("fl_id_instr", id_instr, NOP);
    chk("fl_id_pc_hold", id_pc, 32'h80);
    chk("fl_id_pc_inc4_hold", id_pc_inc4, 32'h84);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("fl_still_empty", {31'd0, id_valid}, 32'd0);

    // Flush in ONE with a coincident fetch beat that must be dropped
    drive(1'b1, 32'hC0000005, 32'h90, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hC0000009, 32'h94, 1'b0, 1'b1);
    step();
    chk("fl1_id_valid", {31'd0, id_valid}, 32'd0);
    chk("fl1_if_ready", {31'd0, if_ready}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("fl1_still_empty", {31'd0, id_valid}, 32'd0);

    // Simultaneous in/out while in ONE
    drive(1'b1, 32'hD0000000, 32'hC0, 1'b0, 1'b0);
    step();
    chk("sim_main_d0", id_instr, 32'hD0000000);
    drive(1'b1, 32'hD0000001, 32'hC4, 1'b1, 1'b0);
    step();
    chk("sim_instr_d1", id_instr, 32'hD0000001);
    chk("sim_id_valid", {31'd0, id_valid}, 32'd1);
    chk("sim_if_ready", {31'd0, if_ready}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    chk("sim_drained", {31'd0, id_valid}, 32'd0);

`ifdef IF_ID_STALL_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("sc_after_rst", stall_cnt, 32'd0);
    drive(1'b1, 32'hE0000000, 32'hE0, 1'b0, 1'b0);
    step();
    chk("sc_no_stall_yet", stall_cnt, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (5) step();
    chk("sc_five", stall_cnt, 32'd5);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk("sc_flush_keeps", stall_cnt, 32'd5);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("sc_rst_clears", stall_cnt, 32'd0);
`endif

    // Bounded drain of anything still expected
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      step();
    end
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("total_pops", 32'(n_pops), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- Pipeline register between the fetch stage and the decode stage.
- Captures instruction, PC and PC+4 from fetch and presents them to decode with a valid/ready handshake.
- A 2-entry skid buffer keeps if_ready a pure register output, so no combinational path runs from decode back into fetch.
- Supports flush for branch and jump redirects.

Parameters:
- N, 32, datapath width of instruction and PC fields.
- NOP, 32'h00000013, instruction value driven on id_instr when id_valid is low.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- if_valid  input  1  fetch presents a valid instruction.
- if_instr  input  N  fetched instruction.
- if_pc  input  N  PC of the fetched instruction.
- if_pc_inc4  input  N  PC+4 from fetch.
- if_ready  output  1  pipe can accept this cycle; registered.
- id_valid  output  1  decode-side entry valid.
- id_instr  output  N  instruction to decode.
- id_pc  output  N  PC to decode.
- id_pc_inc4  output  N  PC+4 to decode.
- id_ready  input  1  decode accepts this cycle.
- flush  input  1  discard all buffered entries.
- stall_cnt  output  32  present only with the optional feature.

Behaviour:
- Handshakes:
  - Fetch-side transfer: if_valid && if_ready at posedge.
  - Decode-side transfer: id_valid && id_ready at posedge.
- Storage: main entry (drives id_*) and skid entry. Each entry holds {instr, pc, pc_inc4}.
- State is encoded by occupancy: EMPTY (0 entries), ONE (main only), TWO (main + skid).
- if_ready = (state != TWO), registered.
- id_valid = (state != EMPTY). id_* come from the main entry.
- When id_valid = 0: id_instr = NOP, and id_pc / id_pc_inc4 hold their last values.
- Transitions when flush = 0. Here "in" = fetch transfer and "out" = decode transfer.
  - EMPTY: in -> ONE, main <= if_*; otherwise stay.
  - ONE: in && !out -> TWO, skid <= if_*. in && out -> ONE, main <= if_*. !in && out -> EMPTY. Neither -> hold.
  - TWO: out -> ONE, main <= skid. Otherwise hold. No input is accepted because if_ready = 0.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- While id_valid && !id_ready, the id_* outputs remain stable.
- Flush (highest priority after rst):
  - At posedge, state <= EMPTY and both entries are invalidated.
  - A coincident fetch-side transfer is dropped.
  - A coincident decode-side transfer still counts as consumed by decode. Decode is responsible for ignoring it.
  - if_ready = 1 on the next cycle.
- rst at posedge: state <= EMPTY, if_ready = 1, id_valid = 0, id_instr = NOP, id_pc = 0, id_pc_inc4 = 0, skid contents = 0. Reset mid-transfer discards everything.
- Latency: 1 cycle from fetch transfer to id_valid when empty. Throughput is 1 instruction/cycle when id_ready stays high.
- No arithmetic on the PC. Values pass through unchanged at width N.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists, 32-bit.
  - Increments at each posedge where id_valid && !id_ready && !flush.
  - Wraps from 32'hFFFFFFFF to 0.
  - Cleared by rst; not affected by flush.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with if_valid = 1 -> if_ready = 1, id_valid = 0, id_instr = 32'h00000013, id_pc = 0 after release.
- Streaming: if_valid = 1 with instrs A0..A3 at PCs 0, 4, 8, 12, id_ready = 1 -> id_valid from cycle +1; one instruction per cycle in order; id_pc_inc4 = PC+4 each.
- Backpressure:
  - Sequence: push B0, B1, B2 with id_ready = 0.
  - While id_ready = 0: buffer holds B0 (main) and B1 (skid); if_ready = 0 from cycle +2; id_instr stays B0 throughout; B2 is not accepted.
  - Raise id_ready -> outputs are B0, B1, B2 in consecutive cycles with no loss or duplication.
- Flush with full buffer: state TWO, assert flush with if_valid = 1 (C9) -> next cycle id_valid = 0, if_ready = 1, C9 never appears on id_*.
- Simultaneous in/out in ONE: main = D0, if_valid = 1 (D1), id_ready = 1 -> next cycle id_instr = D1, state ONE, if_ready = 1.
- IF_ID_STALL_CNT_EN: hold id_valid = 1, id_ready = 0 for 5 cycles, then flush -> stall_cnt = 5 and unchanged by the flush; rst -> 0.
